dma_burst_writer: RTL and testbench

Bus-master write engine that drains a block of 32-bit words from the DMA's local 512-entry dual-port SSRAM (port B side) into system memory using burst write transactions on the shared bus. It is the outbound counterpart of the DMA read path: the custom-instruction front end fills the SSRAM from the bus, and this block copies results back out. It is programmed and started by the DMA control logic and reports busy, done and error status back to it.

---
 rtl/dma_burst_writer.sv | 242 ++++++++++++++++++++++++
 tb/tb_dma_burst_writer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_writer.sv
// dma_burst_writer
//
// Bus-master write engine. Copies a block of 32-bit words out of the local
// 512-word SSRAM (port B) into system memory as a series of burst writes on
// the shared wired-OR bus.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge) / asynchronous active-low reset
//   i_start                   one-cycle start pulse, ignored while busy
//   i_bus_start_address[31:0] byte address of the first bus word (bits [1:0] ignored)
//   i_mem_start_address[8:0]  SSRAM index of the first word
//   i_block_size[9:0]         number of words to move (0 = nothing, done only)
//   i_burst_size[7:0]         words per burst minus one
//   o_busy, o_done, o_error   status: busy level, one-cycle done, sticky error
//   o_mem_address[8:0]        SSRAM read address, i_mem_data[31:0] one cycle later
//   o_request / i_granted     bus arbitration
//   o_address_data_out ...    bus master outputs, all zero outside their phase
//   i_busy_in, i_error_in     slave stall (data cycles only) and bus error
module dma_burst_writer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_bus_start_address,
  input  logic [8:0]  i_mem_start_address,
  input  logic [9:0]  i_block_size,
  input  logic [7:0]  i_burst_size,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [8:0]  o_mem_address,
  input  logic [31:0] i_mem_data,
  output logic        o_request,
  input  logic        i_granted,
  output logic [31:0] o_address_data_out,
  output logic [3:0]  o_byte_enables_out,
  output logic [7:0]  o_burst_size_out,
  output logic        o_read_n_write_out,
  output logic        o_begin_transaction_out,
  output logic        o_end_transaction_out,
  output logic        o_data_valid_out,
  input  logic        i_busy_in,
  input  logic        i_error_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_BEGIN, S_WRITE, S_END, S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Bus-side transfer bookkeeping
  logic [31:0] r_bus_addr;
  logic [9:0]  r_remaining;
  logic [7:0]  r_burst_max;
  logic [7:0]  r_beat;
  logic        r_done;
  logic        r_error;

  // SSRAM prefetch side: streams the whole block into a 4-deep FIFO
  logic [8:0]  r_fetch_addr;
  logic [9:0]  r_fetch_left;
  logic        r_rd_vld;
  logic [31:0] r_fifo_q [0:3];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_fifo_cnt;

  logic        w_start_ok;
  logic        w_zero_start;
  logic [9:0]  w_rem_m1;
  logic        w_last_burst;
  logic [7:0]  w_bsize;
  logic [8:0]  w_n;
  logic        w_accept;
  logic        w_last_beat;
  logic        w_abort;
  logic        w_pop;
  logic        w_issue;

  assign w_start_ok   = (r_state == S_IDLE) && i_start && (i_block_size != 10'd0);
  assign w_zero_start = (r_state == S_IDLE) && i_start && (i_block_size == 10'd0);

  // The current burst is the last one when the remaining words fit in it;
  // then its size is remaining-1, otherwise the programmed burst size.
  assign w_rem_m1     = r_remaining - 10'd1;
  assign w_last_burst = (w_rem_m1 <= {2'b00, r_burst_max});
  assign w_bsize      = w_last_burst ? w_rem_m1[7:0] : r_burst_max;
  assign w_n          = {1'b0, w_bsize} + 9'd1;

  assign w_accept     = (r_state == S_WRITE) && !i_busy_in;
  assign w_last_beat  = w_accept && (r_beat == w_bsize);
  assign w_abort      = ((r_state == S_BEGIN) || (r_state == S_WRITE)) && i_error_in;
  assign w_pop        = w_accept && !i_error_in;

  // Only issue a read when its data is guaranteed a FIFO slot: the word in
  // flight on the SSRAM data bus is counted as occupied.
  assign w_issue      = (r_fetch_left != 10'd0) &&
                        ((r_fifo_cnt + {2'b00, r_rd_vld}) < 3'd4);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_ok) w_state_next = S_REQUEST;
      S_REQUEST: if (i_granted) w_state_next = S_BEGIN;
      S_BEGIN:   w_state_next = i_error_in ? S_ERROR : S_WRITE;
      S_WRITE: begin
        // error wins over a simultaneous last-word acceptance
        if (i_error_in)       w_state_next = S_ERROR;
        else if (w_last_beat) w_state_next = S_END;
      end
      S_END:     w_state_next = w_last_burst ? S_IDLE : S_REQUEST;
      S_ERROR:   w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    o_request               = 1'b0;
    o_begin_transaction_out = 1'b0;
    o_end_transaction_out   = 1'b0;
    o_data_valid_out        = 1'b0;
    o_address_data_out      = 32'd0;
    o_byte_enables_out      = 4'd0;
    o_burst_size_out        = 8'd0;
    case (r_state)
      S_REQUEST: o_request = 1'b1;
      S_BEGIN: begin
        o_begin_transaction_out = 1'b1;
        o_address_data_out      = r_bus_addr;
        o_byte_enables_out      = 4'hF;
        o_burst_size_out        = w_bsize;
      end
      S_WRITE: begin
        // FIFO head only advances on acceptance, so a stall holds the word
        o_data_valid_out   = 1'b1;
        o_address_data_out = r_fifo_q[r_rd_ptr];
      end
      S_END, S_ERROR: o_end_transaction_out = 1'b1;
      default: ;
    endcase
    o_busy = (r_state != S_IDLE);
  end

  assign o_read_n_write_out = 1'b0;
  assign o_done             = r_done;
  assign o_error            = r_error;
  assign o_mem_address      = r_fetch_addr;

  // ---------------- bus-side datapath ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_addr  <= 32'd0;
      r_remaining <= 10'd0;
      r_burst_max <= 8'd0;
      r_beat      <= 8'd0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= w_zero_start || ((r_state == S_END) && w_last_burst) ||
                (r_state == S_ERROR);
      if (w_start_ok) begin
        r_bus_addr  <= i_bus_start_address & 32'hFFFF_FFFC;
        r_remaining <= i_block_size;
        r_burst_max <= i_burst_size;
        r_error     <= 1'b0;
      end
      if (w_abort) begin
        r_error <= 1'b1;
      end
      if (r_state == S_BEGIN) begin
        r_beat <= 8'd0;
      end else if (w_accept) begin
        r_beat <= r_beat + 8'd1;
      end
      if (r_state == S_END) begin
        r_bus_addr  <= r_bus_addr + {21'd0, w_n, 2'b00};
        r_remaining <= r_remaining - {1'b0, w_n};
      end
    end
  end

  // ---------------- SSRAM prefetch control ----------------
  // The fetch pointer runs over the whole block independently of burst
  // boundaries; 9-bit arithmetic gives the 511 -> 0 wrap for free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_addr <= 9'd0;
      r_fetch_left <= 10'd0;
      r_rd_vld     <= 1'b0;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_fifo_cnt   <= 3'd0;
    end else if (w_abort) begin
      // abandon everything prefetched or still in flight
      r_fetch_left <= 10'd0;
      r_rd_vld     <= 1'b0;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_fifo_cnt   <= 3'd0;
    end else if (w_start_ok) begin
      r_fetch_addr <= i_mem_start_address;
      r_fetch_left <= i_block_size;
      r_rd_vld     <= 1'b0;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_fifo_cnt   <= 3'd0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_fetch_addr <= r_fetch_addr + 9'd1;
        r_fetch_left <= r_fetch_left - 10'd1;
      end
      if (r_rd_vld) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({r_rd_vld, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 3'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 3'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by r_fifo_cnt
  always_ff @(posedge i_clk) begin
    if (r_rd_vld) begin
      r_fifo_q[r_wr_ptr] <= i_mem_data;
    end
  end

endmodule

// File: tb/tb_dma_burst_writer.sv
// Testbench for dma_burst_writer: directed transfers against an SSRAM model
// and a transfer-level expectation model (burst list + word list).
module tb_dma_burst_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] bus_start;
  logic [8:0]  mem_start;
  logic [9:0]  blk;
  logic [7:0]  bsz;
  logic        busy, done, error;
  logic [8:0]  mem_addr;
  logic [31:0] mem_q;
  logic        req, granted;
  logic [31:0] ad;
  logic [3:0]  be;
  logic [7:0]  bso;
  logic        rnw, begin_o, end_o, dv;
  logic        busy_in, error_in;

  dma_burst_writer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_bus_start_address(bus_start), .i_mem_start_address(mem_start),
    .i_block_size(blk), .i_burst_size(bsz),
    .o_busy(busy), .o_done(done), .o_error(error),
    .o_mem_address(mem_addr), .i_mem_data(mem_q),
    .o_request(req), .i_granted(granted),
    .o_address_data_out(ad), .o_byte_enables_out(be), .o_burst_size_out(bso),
    .o_read_n_write_out(rnw), .o_begin_transaction_out(begin_o),
    .o_end_transaction_out(end_o), .o_data_valid_out(dv),
    .i_busy_in(busy_in), .i_error_in(error_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SSRAM port B: registered read
  logic [31:0] mem [0:511];
  always @(posedge clk) mem_q <= mem[mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- expectation model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [7:0]  bsz;
  } burst_t;

  burst_t      exp_bursts[$];
  logic [31:0] exp_words[$];

  // What the transfer must look like, straight from the burst-splitting rule
  task automatic plan(input logic [31:0] ba, input logic [8:0] ma,
                      input logic [9:0] nblk, input logic [7:0] nbsz);
    int rem = int'(nblk);
    int m   = int'(ma);
    int n;
    logic [31:0] a = ba & 32'hFFFF_FFFC;
    while (rem > 0) begin
      n = (int'(nbsz) + 1 < rem) ? int'(nbsz) + 1 : rem;
      exp_bursts.push_back('{a, 8'(n - 1)});
      for (int i = 0; i < n; i++) exp_words.push_back(mem[9'((m + i) % 512)]);
      a   = a + 32'(4 * n);
      m   = (m + n) % 512;
      rem = rem - n;
    end
  endtask

  // logs of what the DUT actually did, for literal checks
  logic [31:0] log_addr[$];
  logic [7:0]  log_bsz[$];
  logic [31:0] log_words[$];
  int          log_begin_cyc[$];
  int          log_end_cyc[$];
  int          n_done;
  int          cyc = 0;

  // ---------------- per-cycle compare process ----------------
  logic        m_busy, m_done, m_err;
  logic        p_req_gnt, p_begin, p_stall, p_err, p_last;
  logic [31:0] p_data;
  int          beats_left;

  initial begin : compare_proc
    logic   busy_now;
    logic   abort_now;
    logic   acc;
    burst_t b;
    m_busy = 0; m_done = 0; m_err = 0;
    p_req_gnt = 0; p_begin = 0; p_stall = 0; p_err = 0; p_last = 0;
    p_data = 0; beats_left = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_err = 0;
        p_req_gnt = 0; p_begin = 0; p_stall = 0; p_err = 0; p_last = 0;
        beats_left = 0;
        exp_bursts.delete();
        exp_words.delete();
      end else begin
        busy_now  = m_busy;
        abort_now = end_o && p_err;
        if (abort_now) m_err = 1'b1;
        acc = dv && !busy_in && !error_in;

        chk1("busy", busy, m_busy);
        chk1("done", done, m_done);
        chk1("error", error, m_err);
        chk1("read_n_write", rnw, 1'b0);
        if (begin_o) chk("byte_en_begin", {28'd0, be}, 32'hF);
        else begin
          chk("byte_en_idle", {28'd0, be}, 32'h0);
          chk("burst_size_idle", {24'd0, bso}, 32'h0);
        end
        if (!begin_o && !dv) chk("addr_data_idle", ad, 32'h0);
        chk1("phase_exclusive", $countones({req, begin_o, dv, end_o}) <= 1, 1'b1);

        if (begin_o) begin
          log_addr.push_back(ad);
          log_bsz.push_back(bso);
          log_begin_cyc.push_back(cyc);
          chk1("begin_after_grant", p_req_gnt, 1'b1);
          chk1("burst_expected", exp_bursts.size() != 0, 1'b1);
          if (exp_bursts.size() != 0) begin
            b = exp_bursts.pop_front();
            chk("burst_addr", ad, b.addr);
            chk("burst_size", {24'd0, bso}, {24'd0, b.bsz});
            beats_left = int'(b.bsz) + 1;
          end
        end
        if (p_begin) chk1("data_after_begin", dv, 1'b1);
        if (p_stall) begin
          chk1("stall_hold_valid", dv, 1'b1);
          chk("stall_hold_data", ad, p_data);
        end
        if (p_last) chk1("end_after_last_word", end_o, 1'b1);
        if (acc) begin
          log_words.push_back(ad);
          chk1("word_expected", exp_words.size() != 0, 1'b1);
          if (exp_words.size() != 0) chk("word", ad, exp_words.pop_front());
          beats_left--;
        end
        if (end_o) begin
          log_end_cyc.push_back(cyc);
          if (!abort_now) chk("burst_word_count", 32'(beats_left), 32'd0);
        end
        if (done) n_done++;

        // expectations for the next cycle
        m_done = 1'b0;
        if (end_o && (abort_now || exp_bursts.size() == 0)) begin
          m_done = 1'b1;
          m_busy = 1'b0;
          if (abort_now) begin
            exp_bursts.delete();
            exp_words.delete();
          end
        end
        if (start && !busy_now) begin
          if (blk == 10'd0) m_done = 1'b1;
          else begin
            m_busy = 1'b1;
            m_err  = 1'b0;
            plan(bus_start, mem_start, blk, bsz);
          end
        end
        p_last    = acc && (beats_left == 0);
        p_req_gnt = req && granted;
        p_begin   = begin_o;
        p_stall   = dv && busy_in && !error_in;
        p_data    = ad;
        p_err     = error_in && (begin_o || dv);
      end
    end
  end

  // ---------------- bus slave: stall / error by data-cycle index ----------------
  logic [15:0] stall_mask;
  int          err_idx;
  int          dv_idx;

  initial begin : slave_proc
    busy_in  = 1'b0;
    error_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (dv) begin
        busy_in  = stall_mask[dv_idx[3:0]];
        error_in = (dv_idx == err_idx);
        dv_idx++;
      end else begin
        busy_in  = 1'b0;
        error_in = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] ba, input logic [8:0] ma,
                     input logic [9:0] nblk, input logic [7:0] nbsz);
    log_addr.delete(); log_bsz.delete(); log_words.delete();
    log_begin_cyc.delete(); log_end_cyc.delete();
    n_done    = 0;
    dv_idx    = 0;
    bus_start = ba; mem_start = ma; blk = nblk; bsz = nbsz;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    bus_start = 32'hDEAD_BEEF; mem_start = 9'h155; blk = 10'h3FF; bsz = 8'hA5;
  endtask

  task automatic wait_done(input string name);
    logic seen = 1'b0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk1({name, "_done_reached"}, seen, 1'b1);
    tick();
    chk({name, "_words_left"}, 32'(exp_words.size()), 32'd0);
    chk({name, "_done_count"}, 32'(n_done), 32'd1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 0);
    chk({name, "_done"}, {31'd0, done}, 0);
    chk({name, "_error"}, {31'd0, error}, 0);
    chk({name, "_mem_addr"}, {23'd0, mem_addr}, 0);
    chk({name, "_request"}, {31'd0, req}, 0);
    chk({name, "_addr_data"}, ad, 0);
    chk({name, "_bus_ctl"}, {19'd0, be, bso, rnw, begin_o, end_o, dv}, 0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic seen;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0F0 + 32'(i);
    rst_n = 1'b1; start = 1'b0; granted = 1'b1;
    bus_start = 0; mem_start = 0; blk = 0; bsz = 0;
    stall_mask = 16'd0; err_idx = -1; dv_idx = 0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // two 4-word bursts from SSRAM[16..23]
    run(32'h2000, 9'd16, 10'd8, 8'd3);
    chk1("t1_request_next_cycle", req, 1'b1);
    wait_done("t1");
    chk("t1_burst_count", 32'(log_addr.size()), 2);
    chk("t1_addr0", log_addr[0], 32'h2000);
    chk("t1_addr1", log_addr[1], 32'h2010);
    chk("t1_bsz0", {24'd0, log_bsz[0]}, 3);
    chk("t1_bsz1", {24'd0, log_bsz[1]}, 3);
    chk("t1_word_count", 32'(log_words.size()), 8);
    chk("t1_word0", log_words[0], 32'h100);
    chk("t1_word3", log_words[3], 32'h103);
    chk("t1_word4", log_words[4], 32'h104);
    chk("t1_word7", log_words[7], 32'h107);
    chk("t1_burst_cycles", 32'(log_end_cyc[0] - log_begin_cyc[0]), 5);
    chk1("t1_error", error, 1'b0);

    // uneven split, unaligned start address, delayed grant
    granted = 1'b0;
    run(32'h2003, 9'd16, 10'd5, 8'd1);
    repeat (3) begin
      chk1("t2_request_held", req, 1'b1);
      chk1("t2_no_begin_without_grant", begin_o, 1'b0);
      tick();
    end
    granted = 1'b1;
    wait_done("t2");
    chk("t2_burst_count", 32'(log_addr.size()), 3);
    chk("t2_bsz0", {24'd0, log_bsz[0]}, 1);
    chk("t2_bsz1", {24'd0, log_bsz[1]}, 1);
    chk("t2_bsz2", {24'd0, log_bsz[2]}, 0);
    chk("t2_addr0", log_addr[0], 32'h2000);
    chk("t2_addr1", log_addr[1], 32'h2008);
    chk("t2_addr2", log_addr[2], 32'h2010);

    // slave stall on data cycles 2 and 3
    stall_mask = 16'b0110;
    run(32'h3000, 9'd0, 10'd4, 8'd3);
    wait_done("t3");
    stall_mask = 16'd0;
    chk("t3_word_count", 32'(log_words.size()), 4);
    chk("t3_word1", log_words[1], 32'hF1);
    chk("t3_word3", log_words[3], 32'hF3);
    chk("t3_burst_cycles", 32'(log_end_cyc[0] - log_begin_cyc[0]), 7);

    // SSRAM wrap 511 -> 0, single oversized burst
    run(32'h4000, 9'd510, 10'd4, 8'd7);
    wait_done("t4");
    chk("t4_bsz0", {24'd0, log_bsz[0]}, 3);
    chk("t4_word0", log_words[0], 32'h2EE);
    chk("t4_word1", log_words[1], 32'h2EF);
    chk("t4_word2", log_words[2], 32'hF0);
    chk("t4_word3", log_words[3], 32'hF1);

    // bus address wrap at 2^32
    run(32'hFFFF_FFF8, 9'd510, 10'd4, 8'd1);
    wait_done("t4b");
    chk("t4b_addr0", log_addr[0], 32'hFFFF_FFF8);
    chk("t4b_addr1", log_addr[1], 32'h0000_0000);

    // bus error on the second data cycle
    err_idx = 1;
    run(32'h5000, 9'd16, 10'd8, 8'd3);
    wait_done("t5");
    err_idx = -1;
    chk1("t5_error_sticky", error, 1'b1);
    chk("t5_words_before_error", 32'(log_words.size()), 1);
    chk("t5_end_count", 32'(log_end_cyc.size()), 1);
    run(32'h5000, 9'd16, 10'd4, 8'd3);
    chk1("t5_error_cleared", error, 1'b0);
    wait_done("t5b");
    chk1("t5b_error", error, 1'b0);

    // reset in the middle of a burst
    run(32'h6000, 9'd16, 10'd8, 8'd3);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = dv;
    end
    chk1("t6_reached_write", seen, 1'b1);
    rst_n = 1'b0;
    #1 chk_all_zero("t6_mid_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // zero-length start
    run(32'h7000, 9'd0, 10'd0, 8'd3);
    chk1("t7_done_next", done, 1'b1);
    chk1("t7_busy", busy, 1'b0);
    repeat (4) begin
      chk1("t7_no_request", req, 1'b0);
      tick();
    end
    chk("t7_done_count", 32'(n_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
